// File: rtl/rm_controller.sv
// Instruction register and sequencing FSM for the 16-bit register/ALU datapath.
// Captures an instruction in WAIT and steps the datapath one control set per clock.
module rm_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_OP        = 3'd5,
        S_WRITE_C   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, needs_a, supported;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    // MVN (op=11) has no Rn operand; ADD, CMP and AND read both registers.
    assign needs_a    = is_alu && (op != 2'b11);
    assign supported  = is_mov_imm || is_mov_reg || is_alu;

    assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (load) ir_d = in;
                if (s)    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)      state_d = S_WRITE_IMM;
                else if (needs_a)    state_d = S_GET_A;
                else if (supported)  state_d = S_GET_B;
                else                 state_d = S_WAIT;
            end
            S_WRITE_IMM: state_d = S_WAIT;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_OP;
            S_OP:        state_d = is_cmp ? S_WAIT : S_WRITE_C;
            S_WRITE_C:   state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore outputs: everything derives from the registered state and IR.
    always_comb begin
        w        = 1'b0;
        err      = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state_q)
            S_WAIT:   w = 1'b1;
            S_DECODE: err = !supported;
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = 2'b10;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_OP: begin
                shift = sh;
                if (is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else begin
                    ALUop = op;
                end
                if (is_cmp) loads = 1'b1;
                else        loadc = 1'b1;
            end
            S_WRITE_C: begin
                writenum = rd;
                vsel     = 2'b00;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
